// File: rtl/dcache_victim_buffer_pkg.sv
// ============================================================================
// Module      : dcache_victim_buffer_pkg
// Description : Shared dcache victim-buffer types: drain FSM states and the
//               line data container sized from the configured line width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DCACHE_LINE_WORD
`define DCACHE_LINE_WORD 4
`endif

package dcache_victim_buffer_pkg;

  localparam int VB_LINE_WORD = `DCACHE_LINE_WORD;

  typedef logic [VB_LINE_WORD*32-1:0] line_data_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE = 2'd0,
    DRAIN_REQ  = 2'd1,
    DRAIN_WAIT = 2'd2
  } drain_state_t;

  // Number of byte-offset bits ignored when comparing line addresses.
  function automatic int unsigned line_off_bits(input int unsigned line_word);
    return $clog2(line_word * 4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_victim_buffer_if.sv
// ============================================================================
// Module      : dcache_victim_buffer_if
// Description : Push / AXI-write / lookup / occupancy bundle of the victim
//               buffer. master = dcache + AXI side, slave = buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dcache_victim_buffer_if
  import dcache_victim_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LINE_WORD = `DCACHE_LINE_WORD
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                      push_valid;
  logic [31:0]               push_addr;
  logic [LINE_WORD*32-1:0]   push_data;
  logic                      push_ready;

  logic                      wr_req;
  logic [31:0]               wr_addr;
  logic [LINE_WORD*32-1:0]   wr_data;
  logic                      wr_rdy;
  logic                      wr_valid;

  logic [31:0]               lk_addr;
  logic                      lk_hit;
  logic [LINE_WORD*32-1:0]   lk_data;

  logic                      empty;
  logic [CNT_W-1:0]          count;

  modport master (
    output push_valid, push_addr, push_data, wr_rdy, wr_valid, lk_addr,
    input  push_ready, wr_req, wr_addr, wr_data, lk_hit, lk_data, empty, count
  );

  modport slave (
    input  push_valid, push_addr, push_data, wr_rdy, wr_valid, lk_addr,
    output push_ready, wr_req, wr_addr, wr_data, lk_hit, lk_data, empty, count
  );

endinterface

`default_nettype wire

// File: rtl/dcache_victim_match.sv
// ============================================================================
// Module      : dcache_victim_match
// Description : Parallel line-tag comparator with a youngest-match priority
//               encoder; age is the distance of a slot from the FIFO head.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_victim_match
  import dcache_victim_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 28,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [TAG_W-1:0]            tag,
  input  logic [DEPTH-1:0]            mask,
  input  logic [DEPTH-1:0][TAG_W-1:0] entry_tag,
  input  logic [IDX_W-1:0]            head,
  output logic                        hit,
  output logic [IDX_W-1:0]            idx
);

  logic [DEPTH-1:0] w_eq;
  logic [IDX_W-1:0] w_slot;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign w_eq[gi] = mask[gi] && (entry_tag[gi] == tag);
    end
  endgenerate

  // Walk oldest to youngest so the last hit seen is the youngest one.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    w_slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_slot = head + IDX_W'(k);
      if (w_eq[w_slot]) begin
        hit = 1'b1;
        idx = w_slot;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_victim_buffer.sv
// ============================================================================
// Module      : dcache_victim_buffer
// Description : Circular FIFO of evicted dirty dcache lines drained to AXI
//               write, with zero-latency lookup. VICTIM_COALESCE_EN enables
//               merging a push into a matching entry that is not in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_victim_buffer
  import dcache_victim_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LINE_WORD = `DCACHE_LINE_WORD
) (
  input  logic                   clk,
  input  logic                   resetn,
  dcache_victim_buffer_if.slave  bus
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int OFF_BITS = line_off_bits(LINE_WORD);
  localparam int TAG_W    = 32 - OFF_BITS;

  drain_state_t                r_state;
  drain_state_t                w_state_nxt;
  logic [IDX_W-1:0]            r_head;
  logic [IDX_W-1:0]            r_tail;
  logic [CNT_W-1:0]            r_count;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            w_valid_nxt;
  logic [DEPTH-1:0][TAG_W-1:0] r_tag;
  line_data_t                  r_data [DEPTH];

  logic                        w_full;
  logic                        w_in_flight;
  logic                        w_push_ok;
  logic                        w_alloc;
  logic                        w_pop;
  logic                        w_coalesce;
  logic [IDX_W-1:0]            w_wr_idx;
  logic                        w_wr_req;
  logic                        w_lk_hit;
  logic [IDX_W-1:0]            w_lk_idx;
  logic                        w_unused_offsets;

  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_in_flight = (r_state == DRAIN_WAIT);
  assign w_push_ok   = bus.push_valid && !w_full;
  assign w_pop       = w_in_flight && bus.wr_valid;
  assign w_alloc     = w_push_ok && !w_coalesce;

`ifdef VICTIM_COALESCE_EN
  logic [DEPTH-1:0] w_co_mask;
  logic             w_co_hit;
  logic [IDX_W-1:0] w_co_idx;

  // The in-flight head is owned by AXI and must not absorb new data.
  always_comb begin
    w_co_mask = r_valid;
    if (w_in_flight) begin
      w_co_mask[r_head] = 1'b0;
    end
  end

  dcache_victim_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_coalesce_match (
    .tag       (bus.push_addr[31:OFF_BITS]),
    .mask      (w_co_mask),
    .entry_tag (r_tag),
    .head      (r_head),
    .hit       (w_co_hit),
    .idx       (w_co_idx)
  );

  assign w_coalesce = w_push_ok && w_co_hit;
  assign w_wr_idx   = w_coalesce ? w_co_idx : r_tail;
`else
  assign w_coalesce = 1'b0;
  assign w_wr_idx   = r_tail;
`endif

  always_comb begin
    w_valid_nxt = r_valid;
    if (w_pop) begin
      w_valid_nxt[r_head] = 1'b0;
    end
    if (w_alloc) begin
      w_valid_nxt[r_tail] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (w_alloc) begin
        r_tail <= r_tail + IDX_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + IDX_W'(1);
      end
      if (w_alloc && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_alloc && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by r_valid.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[r_tail] <= bus.push_addr[31:OFF_BITS];
    end
    if (w_push_ok) begin
      r_data[w_wr_idx] <= bus.push_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= DRAIN_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DRAIN_IDLE: begin
        if ((r_count != '0) || w_push_ok) begin
          w_state_nxt = DRAIN_REQ;
        end
      end
      DRAIN_REQ: begin
        if (bus.wr_rdy) begin
          w_state_nxt = DRAIN_WAIT;
        end
      end
      DRAIN_WAIT: begin
        if (bus.wr_valid) begin
          w_state_nxt = (r_count > CNT_W'(1)) ? DRAIN_REQ : DRAIN_IDLE;
        end
      end
      default: w_state_nxt = DRAIN_IDLE;
    endcase
  end

  always_comb begin
    w_wr_req = 1'b0;
    if (r_state == DRAIN_REQ) begin
      w_wr_req = 1'b1;
    end
  end

  dcache_victim_match #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_lookup_match (
    .tag       (bus.lk_addr[31:OFF_BITS]),
    .mask      (r_valid),
    .entry_tag (r_tag),
    .head      (r_head),
    .hit       (w_lk_hit),
    .idx       (w_lk_idx)
  );

  assign bus.wr_req     = w_wr_req;
  assign bus.wr_addr    = {r_tag[r_head], {OFF_BITS{1'b0}}};
  assign bus.wr_data    = r_data[r_head];
  assign bus.lk_hit     = w_lk_hit;
  assign bus.lk_data    = w_lk_hit ? r_data[w_lk_idx] : '0;
  assign bus.push_ready = resetn && !w_full;
  assign bus.empty      = (r_count == '0);
  assign bus.count      = r_count;

  assign w_unused_offsets = ^{bus.push_addr[OFF_BITS-1:0], bus.lk_addr[OFF_BITS-1:0]};

endmodule

`default_nettype wire

// File: tb/tb_dcache_victim_buffer.sv
// ============================================================================
// Module      : tb_dcache_victim_buffer
// Description : Directed + randomized bench for dcache_victim_buffer against a
//               queue-based reference model (honours VICTIM_COALESCE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_victim_buffer;
  import dcache_victim_buffer_pkg::*;

  localparam int          DEPTH  = 4;
  localparam int          LW     = VB_LINE_WORD;
  localparam int          OFF    = $clog2(LW * 4);
  localparam logic [31:0] LMASK  = ~((32'd1 << OFF) - 32'd1);
  localparam int          P_IDLE = 0;
  localparam int          P_REQ  = 1;
  localparam int          P_WAIT = 2;

  typedef struct {
    logic [31:0] addr;
    line_data_t  data;
  } line_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  dcache_victim_buffer_if #(.DEPTH(DEPTH), .LINE_WORD(LW)) bus ();

  dcache_victim_buffer #(.DEPTH(DEPTH), .LINE_WORD(LW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  line_t q[$];
  int    phase;
  int    n_checks;
  int    n_errors;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
    return (a & LMASK) == (b & LMASK);
  endfunction

  function automatic line_data_t rnd_line();
    line_data_t d;
    for (int w = 0; w < LW; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  // One clock cycle: apply inputs, check outputs against the model, advance model.
  task automatic tick(input logic pv, input logic [31:0] pa, input line_data_t pd,
                      input logic rdy, input logic wv, input logic [31:0] la);
    int n, hit_i, co_i, nph;
    bit acc, pop;
    @(posedge clk);
    #1;
    bus.push_valid = pv;
    bus.push_addr  = pa;
    bus.push_data  = pd;
    bus.wr_rdy     = rdy;
    bus.wr_valid   = wv;
    bus.lk_addr    = la;
    #1;
    n = q.size();
    check("count", bus.count, n);
    check("empty", bus.empty, n == 0);
    check("push_ready", bus.push_ready, n < DEPTH);
    check("wr_req", bus.wr_req, phase == P_REQ);
    if (phase == P_REQ && n > 0) begin
      check("wr_addr", bus.wr_addr, q[0].addr);
      check("wr_data", bus.wr_data, q[0].data);
    end
    hit_i = -1;
    for (int i = n - 1; i >= 0; i--) if (hit_i < 0 && same_line(q[i].addr, la)) hit_i = i;
    check("lk_hit", bus.lk_hit, hit_i >= 0);
    if (hit_i >= 0) check("lk_data", bus.lk_data, q[hit_i].data);

    acc = pv && (n < DEPTH);
    pop = 1'b0;
    nph = phase;
    case (phase)
      P_IDLE:  if (n > 0 || acc) nph = P_REQ;
      P_REQ:   if (rdy) nph = P_WAIT;
      default: if (wv) begin pop = 1'b1; nph = (n > 1) ? P_REQ : P_IDLE; end
    endcase
    if (acc) begin
      co_i = -1;
`ifdef VICTIM_COALESCE_EN
      for (int i = 0; i < n; i++)
        if (!(i == 0 && phase == P_WAIT) && same_line(q[i].addr, pa)) co_i = i;
`endif
      if (co_i >= 0) q[co_i].data = pd;
      else q.push_back('{pa & LMASK, pd});
    end
    if (pop) void'(q.pop_front());
    phase = nph;
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && q.size() != 0; k++) tick(1'b0, 32'h0, '0, 1'b1, 1'b1, 32'h0);
    tick(1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h0);
    check("drain_empty", bus.empty, 1'b1);
  endtask

  task automatic do_reset(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    @(posedge clk);
    #1;
    resetn         = 1'b0;
    bus.push_valid = 1'b0;
    bus.wr_rdy     = 1'b0;
    bus.wr_valid   = 1'b0;
    bus.lk_addr    = a0;
    #1;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_wr_req", bus.wr_req, 1'b0);
    check("rst_push_ready", bus.push_ready, 1'b0);
    check("rst_lk_hit0", bus.lk_hit, 1'b0);
    bus.lk_addr = a1;
    #1;
    check("rst_lk_hit1", bus.lk_hit, 1'b0);
    bus.lk_addr = a2;
    #1;
    check("rst_lk_hit2", bus.lk_hit, 1'b0);
    q.delete();
    phase = P_IDLE;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("rel_push_ready", bus.push_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] pool [6];
    line_data_t  da, db;
    logic [31:0] a, la;

    n_checks = 0;
    n_errors = 0;
    phase    = P_IDLE;
    pool[0] = 32'h0000_0100; pool[1] = 32'h0000_0110; pool[2] = 32'h0000_0200;
    pool[3] = 32'h8000_0010; pool[4] = 32'h8000_0020; pool[5] = 32'h0000_1000;
    bus.push_valid = 1'b0; bus.push_addr = '0; bus.push_data = '0;
    bus.wr_rdy = 1'b0; bus.wr_valid = 1'b0; bus.lk_addr = '0;

    do_reset(32'h0, 32'h100, 32'h200);

    // Single line drains with wr_valid three cycles after the push.
    tick(1'b1, 32'h8000_0010, rnd_line(), 1'b1, 1'b0, 32'h0);
    tick(1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h8000_0010);
    check("single_wr_req", bus.wr_req, 1'b1);
    check("single_wr_addr", bus.wr_addr, 32'h8000_0010);
    tick(1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 32'h0, '0, 1'b1, 1'b1, 32'h0);
    tick(1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h8000_0010);
    check("single_count", bus.count, 0);
    check("single_empty", bus.empty, 1'b1);

    // Fill while stalled; the fifth push must be refused.
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h0000_4000 + 32'(i) * 32'h40, rnd_line(), 1'b0, 1'b0, 32'h0);
    tick(1'b1, 32'h0000_5000, rnd_line(), 1'b0, 1'b0, 32'h0000_5000);
    check("full_push_ready", bus.push_ready, 1'b0);
    check("full_count", bus.count, 4);
    tick(1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0000_5000);
    check("full_refused_lk", bus.lk_hit, 1'b0);
    drain();

    // Same line twice while stalled.
    da = rnd_line();
    db = rnd_line();
    tick(1'b1, 32'h0000_0100, da, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 32'h0000_0100, db, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0000_0104);
`ifdef VICTIM_COALESCE_EN
    check("dup_count", bus.count, 1);
`else
    check("dup_count", bus.count, 2);
`endif
    check("dup_lk_hit", bus.lk_hit, 1'b1);
    check("dup_lk_data", bus.lk_data, db);
    drain();

    // Push to a line that is already in flight allocates a new entry.
    da = rnd_line();
    db = rnd_line();
    tick(1'b1, 32'h0000_0200, da, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 32'h0000_0200, db, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0000_0200);
    check("inflight_count", bus.count, 2);
    check("inflight_lk_data", bus.lk_data, db);
    tick(1'b0, 32'h0, '0, 1'b0, 1'b1, 32'h0);
    tick(1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0);
    check("inflight_next_req", bus.wr_req, 1'b1);
    check("inflight_next_data", bus.wr_data, db);
    drain();

    // Six push/drain pairs walk head and tail past the wrap point.
    for (int i = 0; i < 6; i++) begin
      a = 32'h0000_2000 + 32'(i) * 32'h40;
      tick(1'b1, a, rnd_line(), 1'b1, 1'b0, 32'h0);
      tick(1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h0);
      check("wrap_wr_addr", bus.wr_addr, a);
      tick(1'b0, 32'h0, '0, 1'b1, 1'b1, a);
    end
    drain();

    // Reset while a write is in flight with three entries held.
    tick(1'b1, 32'h0000_0300, rnd_line(), 1'b0, 1'b0, 32'h0);
    tick(1'b1, 32'h0000_0340, rnd_line(), 1'b0, 1'b0, 32'h0);
    tick(1'b1, 32'h0000_0380, rnd_line(), 1'b0, 1'b0, 32'h0);
    tick(1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h0000_0340);
    tick(1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0000_0380);
    do_reset(32'h0000_0300, 32'h0000_0340, 32'h0000_0380);
    tick(1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0000_0340);
    check("post_rst_lk_hit", bus.lk_hit, 1'b0);
    check("post_rst_wr_req", bus.wr_req, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      a  = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, (1 << OFF) - 1));
      la = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, (1 << OFF) - 1));
      tick($urandom_range(0, 99) < 45, a, rnd_line(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) == 0, la);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
